// File: rtl/wb_commit_unit.sv
`default_nettype none
//==============================================================================
// Module   : wb_commit_unit
// Summary  : Writeback commit stage for the integer register file. Buffers ALU
//            results in a small FIFO, arbitrates round-robin against the
//            load/store unit, issues one registered write per cycle and keeps
//            a per-register pending-write scoreboard for RAW stall queries.
// Options  : define WB_COMMIT_TRACE_EN to print every committed write
//            (register index, data, FIFO occupancy) in simulation.
// Revision : 1.0 - initial release
//==============================================================================
module wb_commit_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // Issue side: destination registers that will be written later
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    // ALU result stream (buffered)
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    // Load result stream (held by the LSU until accepted)
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    // Decode hazard queries
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    // Register file write port
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_data
);

    localparam int c_NUM_REGS = 1 << ADDR_WIDTH;
    localparam int c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [1:0]         c_PEND_MAX  = 2'd3;

    //--------------------------------------------------------------------------
    // ALU result FIFO
    //--------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_fifo_cnt;

    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_push;
    logic w_pop;

    assign w_fifo_full  = (r_fifo_cnt == c_FIFO_FULL);
    assign w_fifo_empty = (r_fifo_cnt == '0);
    // Ready depends only on registered occupancy, so a full FIFO never sees
    // a simultaneous push and pop.
    assign alu_ready    = !w_fifo_full;
    assign w_push       = alu_valid && !w_fifo_full;

    // Storage array: contents are don't-care while the slot is not occupied,
    // so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= alu_rd;
            r_fifo_data[r_wr_ptr] <= alu_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Arbitration between FIFO head and LSU
    //--------------------------------------------------------------------------
    // 1 = LSU wins the next contention, 0 = FIFO head wins it.
    logic r_rr_lsu_first;
    logic w_grant_alu;
    logic w_grant_lsu;
    logic w_contend;

    assign w_contend = !w_fifo_empty && lsu_valid;

    // Single candidate wins outright; round-robin only when both compete.
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_lsu = 1'b0;
        if (w_contend) begin
            w_grant_lsu = r_rr_lsu_first;
            w_grant_alu = !r_rr_lsu_first;
        end else begin
            w_grant_alu = !w_fifo_empty;
            w_grant_lsu = lsu_valid;
        end
    end

    assign w_pop     = w_grant_alu;
    assign lsu_ready = w_grant_lsu;

    // Round-robin pointer moves only on contention, away from the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_lsu_first <= 1'b0;
        end else if (w_contend) begin
            r_rr_lsu_first <= w_grant_alu;
        end
    end

    //--------------------------------------------------------------------------
    // Write stage
    //--------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_sel_rd;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_data;

    // Mux the granted candidate onto the write-stage input.
    always_comb begin
        w_sel_rd   = lsu_rd;
        w_sel_data = lsu_data;
        if (w_grant_alu) begin
            w_sel_rd   = r_fifo_rd[r_rd_ptr];
            w_sel_data = r_fifo_data[r_rd_ptr];
        end
    end

    // Register the granted write; x0 results are consumed without a pulse,
    // and index/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen  <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else if (w_grant_alu || w_grant_lsu) begin
            r_wen  <= (w_sel_rd != '0);
            r_rd   <= w_sel_rd;
            r_data <= w_sel_data;
        end else begin
            r_wen  <= 1'b0;
        end
    end

    assign rf_wen  = r_wen;
    assign rf_rd   = r_rd;
    assign rf_data = r_data;

    //--------------------------------------------------------------------------
    // Pending-write scoreboard
    //--------------------------------------------------------------------------
    logic [1:0]            r_pend [c_NUM_REGS];
    logic [c_NUM_REGS-1:0] w_inc;
    logic [c_NUM_REGS-1:0] w_dec;
    logic                  w_issue_fire;

    assign issue_ready  = (r_pend[issue_rd] != c_PEND_MAX) || (issue_rd == '0);
    assign w_issue_fire = issue_valid && issue_ready && (issue_rd != '0);

    // One-hot increment/decrement requests; the decrement lands on the edge
    // that ends the write pulse, so busy clears once the RF holds the value.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (w_issue_fire) begin
            w_inc[issue_rd] = 1'b1;
        end
        if (r_wen) begin
            w_dec[r_rd] = 1'b1;
        end
    end

    // Saturating 2-bit counters; x0 is pinned to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            r_pend[0] <= '0;
            for (int i = 1; i < c_NUM_REGS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_pend[i] <= r_pend[i] + 2'd1;
                end else if (w_dec[i] && !w_inc[i] && (r_pend[i] != 2'd0)) begin
                    r_pend[i] <= r_pend[i] - 2'd1;
                end
            end
        end
    end

    assign rs1_busy = (rs1 != '0) && (r_pend[rs1] != 2'd0);
    assign rs2_busy = (rs2 != '0) && (r_pend[rs2] != 2'd0);

`ifndef SYNTHESIS
    // A commit to a register with nothing pending means the issue side lost
    // track of a destination.
    always_ff @(posedge clk) begin
        if (!rst && r_wen) begin
            assert (r_pend[r_rd] != 2'd0);
        end
    end
`endif

`ifdef WB_COMMIT_TRACE_EN
    // Commit trace for debug runs.
    always_ff @(posedge clk) begin
        if (!rst && r_wen) begin
            $display("wb_commit: x%0d <= 0x%0h (fifo occupancy %0d)", r_rd, r_data, r_fifo_cnt);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
`default_nettype none
//==============================================================================
// Module   : tb_wb_commit_unit
// Summary  : Self-checking bench for wb_commit_unit: directed scenarios
//            followed by random traffic against a queue-based reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_wb_commit_unit;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NREG  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          issue_ready;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          rf_wen;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_data;

    always #5 clk = ~clk;

    wb_commit_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        rs1 = '0; rs2 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue_list(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            issue_valid = 1'b1;
            issue_rd    = AW'(base + k);
            tick();
        end
        issue_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] src_data(input int rd, input bit from_alu);
        return from_alu ? (32'hA100_0000 | DW'(rd)) : (32'hB200_0000 | DW'(rd));
    endfunction

    // Streams a_n ALU results and l_n LSU results (LSU starts at l_start),
    // recording every commit and the per-cycle ready values.
    logic [AW-1:0] got_rd[$];
    logic [DW-1:0] got_data[$];
    bit            obs_ar[$];
    bit            obs_lr[$];

    task automatic stream(input int a_n, input int a_base, input int l_n,
                          input int l_base, input int l_start, input int ncyc);
        int ai = 0;
        int li = 0;
        bit acc_a;
        bit acc_l;
        got_rd.delete(); got_data.delete(); obs_ar.delete(); obs_lr.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (rf_wen) begin
                got_rd.push_back(rf_rd);
                got_data.push_back(rf_data);
            end
            alu_valid = (ai < a_n);
            alu_rd    = AW'(a_base + ai);
            alu_data  = src_data(a_base + ai, 1'b1);
            lsu_valid = (c >= l_start) && (li < l_n);
            lsu_rd    = AW'(l_base + li);
            lsu_data  = src_data(l_base + li, 1'b0);
            settle();
            obs_ar.push_back(alu_ready);
            obs_lr.push_back(lsu_ready);
            acc_a = alu_valid && alu_ready;
            acc_l = lsu_valid && lsu_ready;
            tick();
            if (acc_a) ai++;
            if (acc_l) li++;
        end
        idle_inputs();
    endtask

    // Reference model state for the random phase
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    int            cnt[NREG];
    int            exec_q[$];
    bit            last_alu;
    logic          m_wen;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            exp_seq[$];
        bit            has_h, g_alu, g_lsu, e_ir, e_ar, a_acc, l_acc;
        logic          n_wen;
        logic [AW-1:0] n_rd;
        logic [DW-1:0] n_data;
        ent_t          e;

        rst = 1'b1;
        idle_inputs();

        // ---- Reset and idle
        do_reset();
        rs1 = 5'd5; rs2 = 5'd31;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("idle_rf_wen",    64'(rf_wen),    64'd0);
            check("idle_rf_rd",     64'(rf_rd),     64'd0);
            check("idle_rf_data",   64'(rf_data),   64'd0);
            check("idle_rs1_busy",  64'(rs1_busy),  64'd0);
            check("idle_rs2_busy",  64'(rs2_busy),  64'd0);
            check("idle_alu_ready", 64'(alu_ready), 64'd1);
        end

        // ---- Single ALU write to x5
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd5; settle();
        check("x5_issue_ready", 64'(issue_ready), 64'd1);
        tick();
        issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; rs1 = 5'd5;
        settle();
        check("x5_alu_ready", 64'(alu_ready), 64'd1);
        check("x5_busy_accept", 64'(rs1_busy), 64'd1);
        tick();
        alu_valid = 1'b0; settle();
        check("x5_wen_grant", 64'(rf_wen), 64'd0);
        check("x5_busy_grant", 64'(rs1_busy), 64'd1);
        tick();
        check("x5_wen", 64'(rf_wen), 64'd1);
        check("x5_rd", 64'(rf_rd), 64'd5);
        check("x5_data", 64'(rf_data), 64'hDEADBEEF);
        check("x5_busy_write", 64'(rs1_busy), 64'd1);
        tick();
        check("x5_wen_after", 64'(rf_wen), 64'd0);
        check("x5_busy_clear", 64'(rs1_busy), 64'd0);
        check("x5_rd_hold", 64'(rf_rd), 64'd5);
        check("x5_data_hold", 64'(rf_data), 64'hDEADBEEF);

        // ---- Contention: ALU x1..x4, LSU x10..x13 one cycle later
        do_reset();
        issue_list(1, 4);
        issue_list(10, 4);
        stream(4, 1, 4, 10, 1, 11);
        exp_seq = '{1, 10, 2, 11, 3, 12, 4, 13};
        check("rr_commit_count", 64'(got_rd.size()), 64'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < got_rd.size(); i++) begin
            check("rr_commit_rd", 64'(got_rd[i]), 64'(exp_seq[i]));
            check("rr_commit_data", 64'(got_data[i]), 64'(src_data(exp_seq[i], exp_seq[i] < 10)));
        end
        for (int c = 0; c < 10; c++) begin
            check("rr_lsu_ready", 64'(obs_lr[c]), 64'((c >= 2) && (c <= 8) && (c % 2 == 0)));
        end

        // ---- FIFO fill with LSU continuously valid
        do_reset();
        issue_list(1, 8);
        issue_list(16, 8);
        stream(8, 1, 8, 16, 0, 18);
        for (int c = 0; c < 9; c++) begin
            check("fill_alu_ready", 64'(obs_ar[c]), 64'(c != 7));
        end
        for (int c = 0; c < 16; c++) begin
            check("fill_lsu_ready", 64'(obs_lr[c]), 64'(c % 2 == 0));
        end
        exp_seq.delete();
        for (int k = 0; k < 8; k++) begin
            exp_seq.push_back(16 + k);
            exp_seq.push_back(1 + k);
        end
        check("fill_commit_count", 64'(got_rd.size()), 64'd16);
        for (int i = 0; i < exp_seq.size() && i < got_rd.size(); i++) begin
            check("fill_commit_rd", 64'(got_rd[i]), 64'(exp_seq[i]));
            check("fill_commit_data", 64'(got_data[i]), 64'(src_data(exp_seq[i], exp_seq[i] < 16)));
        end

        // ---- Scoreboard saturation on x7
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1'b1; issue_rd = 5'd7; settle();
            check("sat_issue_ready_x7", 64'(issue_ready), 64'd1);
            tick();
        end
        issue_rd = 5'd7; settle();
        check("sat_full_x7", 64'(issue_ready), 64'd0);
        issue_rd = 5'd8; settle();
        check("sat_x8_ready", 64'(issue_ready), 64'd1);
        tick();
        issue_valid = 1'b0; issue_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd8;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77; settle();
        check("sat_still_full", 64'(issue_ready), 64'd0);
        check("sat_x8_busy", 64'(rs2_busy), 64'd1);
        tick();
        alu_valid = 1'b0; settle();
        check("sat_full_grant", 64'(issue_ready), 64'd0);
        tick();
        settle();
        check("sat_commit_wen", 64'(rf_wen), 64'd1);
        check("sat_commit_rd", 64'(rf_rd), 64'd7);
        check("sat_full_commit", 64'(issue_ready), 64'd0);
        tick();
        settle();
        check("sat_ready_after", 64'(issue_ready), 64'd1);
        check("sat_x7_busy", 64'(rs1_busy), 64'd1);

        // ---- ALU write to x0
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd0; settle();
        check("x0_issue_ready", 64'(issue_ready), 64'd1);
        tick();
        issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234; rs1 = 5'd0;
        settle();
        check("x0_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("x0_no_wen", 64'(rf_wen), 64'd0);
            check("x0_busy", 64'(rs1_busy), 64'd0);
            if (k == 1) begin
                check("x0_rf_data", 64'(rf_data), 64'h1234);
            end
            tick();
        end

        // ---- Reset with three entries buffered
        do_reset();
        issue_list(1, 5);
        issue_list(16, 5);
        stream(5, 1, 5, 16, 0, 5);
        rs1 = 5'd5; rs2 = 5'd20; settle();
        check("mid_busy_before", 64'(rs1_busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; settle();
        check("mid_rf_wen", 64'(rf_wen), 64'd0);
        check("mid_rf_rd", 64'(rf_rd), 64'd0);
        check("mid_rf_data", 64'(rf_data), 64'd0);
        check("mid_alu_ready", 64'(alu_ready), 64'd1);
        check("mid_rs1_busy", 64'(rs1_busy), 64'd0);
        check("mid_rs2_busy", 64'(rs2_busy), 64'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("mid_no_wen", 64'(rf_wen), 64'd0);
        end

        // ---- Random traffic against the reference model
        do_reset();
        foreach (cnt[i]) cnt[i] = 0;
        mq.delete(); exec_q.delete();
        last_alu = 1'b0; m_wen = 1'b0; m_rd = '0; m_data = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            check("rnd_rf_wen", 64'(rf_wen), 64'(m_wen));
            check("rnd_rf_rd", 64'(rf_rd), 64'(m_rd));
            check("rnd_rf_data", 64'(rf_data), 64'(m_data));
            issue_valid = (exec_q.size() < 10) && ($urandom_range(0, 2) != 0);
            issue_rd    = AW'($urandom_range(0, 7));
            if (!alu_valid && exec_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                alu_valid = 1'b1;
                alu_rd    = AW'(exec_q.pop_front());
                alu_data  = $urandom;
            end
            if (!lsu_valid && exec_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                lsu_valid = 1'b1;
                lsu_rd    = AW'(exec_q.pop_front());
                lsu_data  = $urandom;
            end
            rs1 = AW'($urandom_range(0, 8));
            rs2 = AW'($urandom_range(0, 8));
            settle();
            has_h = (mq.size() > 0);
            e_ir  = (issue_rd == '0) || (cnt[issue_rd] != 3);
            e_ar  = (mq.size() < DEPTH);
            g_alu = (has_h && lsu_valid) ? !last_alu : has_h;
            g_lsu = lsu_valid && !g_alu;
            check("rnd_issue_ready", 64'(issue_ready), 64'(e_ir));
            check("rnd_alu_ready", 64'(alu_ready), 64'(e_ar));
            check("rnd_lsu_ready", 64'(lsu_ready), 64'(g_lsu));
            check("rnd_rs1_busy", 64'(rs1_busy), 64'((rs1 != '0) && (cnt[rs1] != 0)));
            check("rnd_rs2_busy", 64'(rs2_busy), 64'((rs2 != '0) && (cnt[rs2] != 0)));
            if (g_alu) begin
                e = mq.pop_front();
                n_rd = e.rd; n_data = e.data; n_wen = (e.rd != '0);
            end else if (g_lsu) begin
                n_rd = lsu_rd; n_data = lsu_data; n_wen = (lsu_rd != '0);
            end else begin
                n_rd = m_rd; n_data = m_data; n_wen = 1'b0;
            end
            if (has_h && lsu_valid) last_alu = g_alu;
            a_acc = alu_valid && e_ar;
            l_acc = g_lsu;
            if (a_acc) begin
                e.rd = alu_rd; e.data = alu_data;
                mq.push_back(e);
            end
            if (m_wen) cnt[m_rd]--;
            if (issue_valid && e_ir) begin
                if (issue_rd != '0) cnt[issue_rd]++;
                exec_q.push_back(int'(issue_rd));
            end
            m_wen = n_wen; m_rd = n_rd; m_data = n_data;
            tick();
            if (a_acc) alu_valid = 1'b0;
            if (l_acc) lsu_valid = 1'b0;
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
